// File: rtl/mc_seq_pkg.sv
// Shared state codes and defaults for the multi-cycle sequencer, its memory
// wait timer, the instruction-class controller and the testbench.
package mc_seq_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_ERR    = 3'd7;

    localparam int MEM_TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_FETCH  = ST_FETCH,
        S_DECODE = ST_DECODE,
        S_EXEC   = ST_EXEC,
        S_MEM    = ST_MEM,
        S_WB     = ST_WB,
        S_ERR    = ST_ERR
    } state_t;

endpackage

// File: rtl/mc_sequencer_if.sv
// Memory request/acknowledge handshake between the sequencer and memory.
interface mc_sequencer_if;

    logic MemReq;
    logic MemWe;
    logic MemAck;

    modport master (output MemReq, output MemWe, input MemAck);
    modport slave  (input MemReq, input MemWe, output MemAck);

endinterface

// File: rtl/mc_sequencer_mem_wait_timer.sv
// Counts request cycles without an acknowledge; flags expiry on the cycle
// whose missing ack would bring the count up to MEM_TIMEOUT.
module mem_wait_timer
    import mc_seq_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    input  logic mem_ack,
    output logic expired
);

    logic [7:0] count;
    logic [8:0] count_inc;

    assign count_inc = {1'b0, count} + 9'd1;

    // Look-ahead so the FSM can leave for ERR in the same cycle the count hits the limit.
    assign expired = count_en && !mem_ack && (count_inc == 9'(MEM_TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (count_en && !mem_ack) begin
            count <= count_inc[7:0];
        end
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer issuing datapath write strobes.
// Performance counters are built only when MC_SEQ_PERF_EN is defined.
module mc_sequencer
    import mc_seq_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Run,
    input  logic                 IsLoad,
    input  logic                 IsStore,
    input  logic                 IsBranch,
    input  logic                 IsJump,
    input  logic                 RegWrReq,
    mc_sequencer_if.master       mem,
    output logic                 IRWr,
    output logic                 PCWr,
    output logic                 RegWrEn,
    output logic                 InstRet,
    output logic [2:0]           State,
    output logic                 Busy,
    output logic                 Err,
    output logic [CNT_W-1:0]     CycleCnt,
    output logic [CNT_W-1:0]     InstCnt
);

    state_t state, next_state;
    logic   retire;
    logic   timer_en;
    logic   timer_clear;
    logic   expired;

    assign timer_en    = (state == S_FETCH) || (state == S_MEM);
    assign timer_clear = ((next_state == S_FETCH) || (next_state == S_MEM)) && (next_state != state);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk      (Clk),
        .rst_n    (Reset),
        .clear    (timer_clear),
        .count_en (timer_en),
        .mem_ack  (mem.MemAck),
        .expired  (expired)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        mem.MemReq = 1'b0;
        mem.MemWe  = 1'b0;
        IRWr       = 1'b0;
        PCWr       = 1'b0;
        RegWrEn    = 1'b0;
        retire     = 1'b0;
        case (state)
            S_IDLE: begin
                if (Run) next_state = S_FETCH;
            end
            S_FETCH: begin
                mem.MemReq = 1'b1;
                if (mem.MemAck) begin
                    IRWr       = 1'b1;
                    next_state = S_DECODE;
                end else if (expired) begin
                    next_state = S_ERR;
                end
            end
            S_DECODE: next_state = S_EXEC;
            S_EXEC: begin
                if (IsJump || IsBranch) begin
                    PCWr   = 1'b1;
                    retire = 1'b1;
                end else if (IsLoad || IsStore) begin
                    next_state = S_MEM;
                end else begin
                    next_state = S_WB;
                end
            end
            S_MEM: begin
                mem.MemReq = 1'b1;
                mem.MemWe  = IsStore;
                if (mem.MemAck) begin
                    if (IsLoad) begin
                        next_state = S_WB;
                    end else begin
                        PCWr   = 1'b1;
                        retire = 1'b1;
                    end
                end else if (expired) begin
                    next_state = S_ERR;
                end
            end
            S_WB: begin
                RegWrEn = RegWrReq;
                PCWr    = 1'b1;
                retire  = 1'b1;
            end
            S_ERR:   next_state = S_ERR;
            default: next_state = S_IDLE;
        endcase
        if (retire) next_state = Run ? S_FETCH : S_IDLE;
    end

    assign InstRet = retire;
    assign State   = state;
    assign Busy    = (state != S_IDLE) && (state != S_ERR);
    assign Err     = (state == S_ERR);

`ifdef MC_SEQ_PERF_EN
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            CycleCnt <= '0;
            InstCnt  <= '0;
        end else begin
            if (Busy)    CycleCnt <= CycleCnt + 1'b1;
            if (InstRet) InstCnt  <= InstCnt + 1'b1;
        end
    end
`else
    assign CycleCnt = '0;
    assign InstCnt  = '0;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Randomized testbench for mc_sequencer with a transaction-level reference model.
module tb_mc_sequencer;
    import mc_seq_pkg::*;

    localparam int TMO   = 3;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic run = 1'b0, is_load = 1'b0, is_store = 1'b0, is_branch = 1'b0, is_jump = 1'b0, reg_wr_req = 1'b0;
    logic ir_wr, pc_wr, reg_wr_en, inst_ret, busy, err;
    logic [2:0] state;
    logic [CNT_W-1:0] cycle_cnt, inst_cnt;

    mc_sequencer_if bus();

    mc_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
        .Clk(clk), .Reset(reset_n), .Run(run),
        .IsLoad(is_load), .IsStore(is_store), .IsBranch(is_branch), .IsJump(is_jump),
        .RegWrReq(reg_wr_req), .mem(bus),
        .IRWr(ir_wr), .PCWr(pc_wr), .RegWrEn(reg_wr_en), .InstRet(inst_ret),
        .State(state), .Busy(busy), .Err(err), .CycleCnt(cycle_cnt), .InstCnt(inst_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [CNT_W-1:0] exp_inst = '0;
    logic [CNT_W-1:0] exp_cyc = '0;

    typedef struct {
        logic [10:0] v;
        logic        ack;
        logic        run;
    } cyc_t;

    // Packed observation: {State, MemReq, MemWe, IRWr, PCWr, RegWrEn, InstRet, Busy, Err}
    function automatic logic [10:0] act_vec();
        return {state, bus.MemReq, bus.MemWe, ir_wr, pc_wr, reg_wr_en, inst_ret, busy, err};
    endfunction

    function automatic logic [10:0] mk(input int st, input bit mreq, input bit mwe, input bit irwr,
                                       input bit pcwr, input bit rwe, input bit iret);
        bit b, e;
        b = (st != 0) && (st != 7);
        e = (st == 7);
        return {st[2:0], mreq, mwe, irwr, pcwr, rwe, iret, b, e};
    endfunction

    function automatic logic [CNT_W-1:0] want_cyc();
`ifdef MC_SEQ_PERF_EN
        return exp_cyc;
`else
        return '0;
`endif
    endfunction

    function automatic logic [CNT_W-1:0] want_inst();
`ifdef MC_SEQ_PERF_EN
        return exp_inst;
`else
        return '0;
`endif
    endfunction

    // cls: 0 ALU, 1 load, 2 store, 3 branch, 4 jump, 5 jump+load.
    // fd/md: ack delay in FETCH/MEM; a delay >= TMO means the ack never comes.
    task automatic run_instr(input int cls, input int fd, input int md, input bit rw,
                             input bit run_next, input bit from_idle, input string nm,
                             output bit errd);
        cyc_t q[$];
        bit jmp, ld, st, a;
        logic [10:0] got;
        jmp = (cls >= 3);
        ld  = (cls == 1);
        st  = (cls == 2);
        errd = 1'b0;
        is_jump    = (cls == 4) || (cls == 5);
        is_branch  = (cls == 3) ? 1'b1 : (cls == 4 || cls == 5) ? 1'($urandom_range(0, 1)) : 1'b0;
        is_load    = (cls == 1 || cls == 5) ? 1'b1 : (cls == 3 || cls == 4) ? 1'($urandom_range(0, 1)) : 1'b0;
        is_store   = (cls == 2) ? 1'b1 : (cls == 3 || cls == 4) ? 1'($urandom_range(0, 1)) : 1'b0;
        reg_wr_req = rw;
        if (from_idle) q.push_back('{mk(0, 0, 0, 0, 0, 0, 0), 1'($urandom_range(0, 1)), 1'b1});
        for (int k = 0; ; k++) begin
            if (k == TMO) begin errd = 1'b1; break; end
            a = (k == fd);
            q.push_back('{mk(1, 1, 0, a, 0, 0, 0), a, 1'b1});
            if (a) break;
        end
        if (!errd) begin
            q.push_back('{mk(2, 0, 0, 0, 0, 0, 0), 1'($urandom_range(0, 1)), run_next});
            q.push_back('{mk(3, 0, 0, 0, jmp, 0, jmp), 1'($urandom_range(0, 1)), run_next});
            if (!jmp && (ld || st)) begin
                for (int k = 0; ; k++) begin
                    if (k == TMO) begin errd = 1'b1; break; end
                    a = (k == md);
                    q.push_back('{mk(4, 1, st, 0, a && st, 0, a && st), a, run_next});
                    if (a) break;
                end
            end
            if (!errd && (cls == 0 || ld))
                q.push_back('{mk(5, 0, 0, 0, 1, rw, 1), 1'($urandom_range(0, 1)), run_next});
        end
        if (errd)
            for (int k = 0; k < 4; k++)
                q.push_back('{mk(7, 0, 0, 0, 0, 0, 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))});
        foreach (q[k]) begin
            bus.MemAck = q[k].ack;
            run = q[k].run;
            @(negedge clk);
            got = act_vec();
            vectors++;
            if (got !== q[k].v) begin
                miscompares++;
                $display("FAIL %s cyc%0d: got %b expected %b", nm, k, got, q[k].v);
            end
            @(posedge clk);
            #1;
            if (q[k].v[1]) exp_cyc = exp_cyc + 1'b1;
            if (q[k].v[2]) exp_inst = exp_inst + 1'b1;
        end
        vectors++;
        if (inst_cnt !== want_inst()) begin
            miscompares++;
            $display("FAIL %s InstCnt: got %0d expected %0d", nm, inst_cnt, want_inst());
        end
        vectors++;
        if (cycle_cnt !== want_cyc()) begin
            miscompares++;
            $display("FAIL %s CycleCnt: got %0d expected %0d", nm, cycle_cnt, want_cyc());
        end
    endtask

    task automatic do_reset(input string nm);
        reset_n = 1'b0;
        run = 1'b1;
        bus.MemAck = 1'b1;
        is_jump = 1'b1;
        #2;
        vectors++;
        if ({act_vec(), cycle_cnt, inst_cnt} !== '0) begin
            miscompares++;
            $display("FAIL %s: got %b/%0d/%0d expected all zero", nm, act_vec(), cycle_cnt, inst_cnt);
        end
        @(posedge clk);
        #1;
        vectors++;
        if ({act_vec(), cycle_cnt, inst_cnt} !== '0) begin
            miscompares++;
            $display("FAIL %s_held: got %b/%0d/%0d expected all zero", nm, act_vec(), cycle_cnt, inst_cnt);
        end
        reset_n = 1'b1;
        exp_cyc = '0;
        exp_inst = '0;
    endtask

    task automatic test_reset();
        do_reset("reset");
    endtask

    task automatic test_alu();
        bit e;
        run_instr(0, 0, 0, 1'b1, 1'b1, 1'b1, "alu", e);
    endtask

    task automatic test_load();
        bit e;
        run_instr(1, 0, 2, 1'b1, 1'b1, 1'b0, "load_wait2", e);
    endtask

    task automatic test_store_jump();
        bit e;
        run_instr(2, 0, 0, 1'b0, 1'b1, 1'b0, "store", e);
        run_instr(4, 0, 0, 1'b0, 1'b1, 1'b0, "jump", e);
    endtask

    task automatic test_priority();
        bit e;
        run_instr(5, 0, 0, 1'b1, 1'b1, 1'b0, "jump_and_load", e);
    endtask

    task automatic test_boundary();
        bit e;
        run_instr(2, TMO - 1, TMO - 1, 1'b0, 1'b1, 1'b0, "ack_last_wait", e);
        run_instr(1, TMO - 1, TMO - 1, 1'b1, 1'b1, 1'b0, "ack_last_wait_ld", e);
    endtask

    task automatic test_run_drop();
        bit e;
        run_instr(0, $urandom_range(0, TMO - 1), 0, 1'b1, 1'b0, 1'b0, "run_drop", e);
        for (int k = 0; k < 3; k++) begin
            bus.MemAck = 1'($urandom_range(0, 1));
            @(negedge clk);
            vectors++;
            if (act_vec() !== mk(0, 0, 0, 0, 0, 0, 0)) begin
                miscompares++;
                $display("FAIL run_drop_idle%0d: got %b expected %b", k, act_vec(), mk(0, 0, 0, 0, 0, 0, 0));
            end
            @(posedge clk);
            #1;
            vectors++;
            if (cycle_cnt !== want_cyc()) begin
                miscompares++;
                $display("FAIL run_drop_cyc%0d: got %0d expected %0d", k, cycle_cnt, want_cyc());
            end
        end
    endtask

    task automatic test_random();
        bit idle = 1'b1;
        bit e, rn;
        for (int n = 0; n < 40; n++) begin
            rn = ($urandom_range(0, 3) != 0);
            run_instr($urandom_range(0, 5), $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1),
                      1'($urandom_range(0, 1)), rn, idle, "random", e);
            idle = !rn;
        end
        if (!idle) begin
            run_instr(3, 0, 0, 1'b0, 1'b0, 1'b0, "random_end", e);
        end
    endtask

    task automatic test_timeout();
        bit e;
        run_instr(0, TMO, 0, 1'b0, 1'b1, 1'b1, "fetch_timeout", e);
        vectors++;
        if (e !== 1'b1 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL fetch_timeout_err: got %b expected 1", err);
        end
        do_reset("reset_from_err");
        run_instr(1, 1, TMO, 1'b1, 1'b1, 1'b1, "mem_timeout", e);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL mem_timeout_err: got %b expected 1", err);
        end
        do_reset("reset_from_mem_err");
    endtask

    task automatic test_reset_mid();
        run = 1'b1;
        bus.MemAck = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vectors++;
        if (act_vec() !== mk(1, 1, 0, 1, 0, 0, 0)) begin
            miscompares++;
            $display("FAIL reset_mid_fetch: got %b expected %b", act_vec(), mk(1, 1, 0, 1, 0, 0, 0));
        end
        #1;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({act_vec(), cycle_cnt, inst_cnt} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_async: got %b expected all zero", act_vec());
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_cyc = '0;
        exp_inst = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.MemAck = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_alu();
        test_load();
        test_store_jump();
        test_priority();
        test_boundary();
        test_run_drop();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
